// File: rtl/spmv_group_packer.sv
// Packs nonzero (matrix, vector, end-of-row) entries into 4-lane groups for the
// sparse MxV ALU pipeline, deriving the row-boundary code and pacing issues.
module spmv_group_packer #(
    parameter int K         = 4,
    parameter int ISSUE_GAP = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_mat,
    input  logic [7:0]     in_vec,
    input  logic           in_last,
    input  logic           flush,
    output logic [8*K-1:0] matrix_in,
    output logic [8*K-1:0] vector_in,
    output logic [3:0]     IPV,
    output logic [4:0]     ones,
    output logic           grp_last,
    output logic           out_fire,
    output logic           busy,
    output logic           err_zero
);

    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    logic [2:0]     cnt;
    logic           flush_pend;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     lane_mat [K];
    logic [7:0]     lane_vec [K];
    logic [K-1:0]   lane_last;

    logic           accept;
    logic           take;
    logic           issue;
    logic [8*K-1:0] grp_mat;
    logic [8*K-1:0] grp_vec;
    logic [3:0]     grp_ipv;
    logic [4:0]     grp_ones;
    logic           grp_last_c;

    assign in_ready = (cnt < 3'(K)) & ~flush_pend;
    assign accept   = in_valid & in_ready;
    // Zero matrix values complete the handshake but are never packed.
    assign take     = accept & (in_mat != 8'd0);
    assign issue    = ((cnt == 3'(K)) | (flush_pend & (cnt != 3'd0))) & (gap_cnt == '0);
    assign busy     = (cnt != 3'd0) | flush_pend | (gap_cnt != '0);

    // Assemble the outgoing group; lanes past the last real one are zero and break-free.
    always_comb begin
        grp_mat    = '0;
        grp_vec    = '0;
        grp_ipv    = '0;
        grp_last_c = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (3'(i) < cnt) begin
                grp_mat[8*(K-1-i) +: 8] = lane_mat[i];
                grp_vec[8*(K-1-i) +: 8] = lane_vec[i];
            end
            if (3'(i + 1) == cnt) begin
                grp_last_c = lane_last[i];
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (3'(j + 1) < cnt) begin
                grp_ipv[2-j] = lane_last[j];
            end
        end
        grp_ones = 5'd1 + 5'(grp_ipv[0]) + 5'(grp_ipv[1]) + 5'(grp_ipv[2]);
    end

    // IPV/ones/grp_last hold between issues because the L1 map table latches on en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 3'd0;
            flush_pend <= 1'b0;
            gap_cnt    <= '0;
            lane_last  <= '0;
            for (int i = 0; i < K; i++) begin
                lane_mat[i] <= 8'd0;
                lane_vec[i] <= 8'd0;
            end
            matrix_in  <= '0;
            vector_in  <= '0;
            IPV        <= 4'd0;
            ones       <= 5'd0;
            grp_last   <= 1'b0;
            out_fire   <= 1'b0;
            err_zero   <= 1'b0;
        end else begin
            out_fire  <= issue;
            matrix_in <= issue ? grp_mat : '0;
            vector_in <= issue ? grp_vec : '0;
            if (issue) begin
                IPV        <= grp_ipv;
                ones       <= grp_ones;
                grp_last   <= grp_last_c;
                cnt        <= 3'd0;
                flush_pend <= 1'b0;
                gap_cnt    <= GW'(ISSUE_GAP - 1);
            end else begin
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
                if (take) begin
                    lane_mat[cnt[1:0]]  <= in_mat;
                    lane_vec[cnt[1:0]]  <= in_vec;
                    lane_last[cnt[1:0]] <= in_last;
                    cnt                 <= cnt + 3'd1;
                end
                if (flush && ((cnt != 3'd0) || take) && (cnt != 3'(K))) begin
                    flush_pend <= 1'b1;
                end
            end
            if (accept && (in_mat == 8'd0)) begin
                err_zero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spmv_group_packer.sv
// Scoreboard bench for spmv_group_packer: a lane model predicts each issued
// group, and per-scenario tasks check latency, pacing, flush and reset behaviour.
module tb_spmv_group_packer;

    typedef struct {
        logic [7:0] m;
        logic [7:0] v;
        logic       l;
    } entry_t;

    typedef struct {
        logic [31:0] m;
        logic [31:0] v;
        logic [3:0]  ipv;
        logic [4:0]  ones;
        logic        gl;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_mat = 8'd0;
    logic [7:0]  in_vec = 8'd0;
    logic        in_last = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] matrix_in;
    logic [31:0] vector_in;
    logic [3:0]  IPV;
    logic [4:0]  ones;
    logic        grp_last;
    logic        out_fire;
    logic        busy;
    logic        err_zero;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fire_count  = 0;
    int last_fire   = 0;
    int prev_fire   = 0;

    entry_t lanes[$];
    grp_t   sb[$];

    spmv_group_packer #(.K(4), .ISSUE_GAP(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mat    (in_mat),
        .in_vec    (in_vec),
        .in_last   (in_last),
        .flush     (flush),
        .matrix_in (matrix_in),
        .vector_in (vector_in),
        .IPV       (IPV),
        .ones      (ones),
        .grp_last  (grp_last),
        .out_fire  (out_fire),
        .busy      (busy),
        .err_zero  (err_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pop and compare a predicted group on every fire; data must be zero between fires.
    always @(negedge clk) begin
        grp_t e;
        if (rst && out_fire) begin
            fire_count = fire_count + 1;
            prev_fire  = last_fire;
            last_fire  = cyc;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_fire: got out_fire=1 m=%h, required no issue", matrix_in);
            end else begin
                e = sb.pop_front();
                if ({matrix_in, vector_in, IPV, ones, grp_last} !== {e.m, e.v, e.ipv, e.ones, e.gl}) begin
                    miscompares++;
                    $display("[TB] FAIL group: got m=%h v=%h ipv=%h ones=%0d gl=%b, required m=%h v=%h ipv=%h ones=%0d gl=%b",
                             matrix_in, vector_in, IPV, ones, grp_last, e.m, e.v, e.ipv, e.ones, e.gl);
                end
            end
        end else if (rst) begin
            vectors++;
            if (matrix_in !== 32'd0 || vector_in !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL idle_zero: got m=%h v=%h, required 0", matrix_in, vector_in);
            end
        end
    end

    task automatic close_group();
        grp_t g;
        int n = lanes.size();
        g.m   = '0;
        g.v   = '0;
        g.ipv = '0;
        g.gl  = lanes[n-1].l;
        for (int i = 0; i < n; i++) begin
            g.m[31-8*i -: 8] = lanes[i].m;
            g.v[31-8*i -: 8] = lanes[i].v;
        end
        for (int i = 0; i < n - 1; i++) g.ipv[2-i] = lanes[i].l;
        g.ones = 5'd1 + 5'(g.ipv[0]) + 5'(g.ipv[1]) + 5'(g.ipv[2]);
        sb.push_back(g);
        lanes.delete();
    endtask

    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] v, input logic l, input logic fl);
        entry_t ent;
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mat   = m;
        in_vec   = v;
        in_last  = l;
        flush    = fl;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_mat   = 8'd0;
        in_vec   = 8'd0;
        in_last  = 1'b0;
        if (m != 8'd0) begin
            ent.m = m;
            ent.v = v;
            ent.l = l;
            lanes.push_back(ent);
            if (lanes.size() == 4) close_group();
        end
        if (fl && lanes.size() > 0) close_group();
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (lanes.size() > 0) close_group();
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || sb.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: got busy=%b pending=%0d, required idle", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_fire !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got in_ready=%b out_fire=%b, required 1 0", in_ready, out_fire);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (matrix_in !== 32'd0 || IPV !== 4'd0 || ones !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got m=%h ipv=%h ones=%0d, required 0 0 0", matrix_in, IPV, ones);
        end
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || err_zero !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got in_ready=%b busy=%b err_zero=%b, required 1 0 0", in_ready, busy, err_zero);
        end
    endtask

    task automatic test_full_group();
        applyStimulus(8'd1, 8'd2, 1'b0, 1'b0);
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
        applyStimulus(8'd5, 8'd6, 1'b0, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_fire !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_before_issue: got out_fire=%b in_ready=%b, required 0 0", out_fire, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_fire !== 1'b1 || matrix_in !== 32'h01030507 || vector_in !== 32'h02040608) begin
            miscompares++;
            $display("[TB] FAIL full_latency: got fire=%b m=%h v=%h, required 1 01030507 02040608", out_fire, matrix_in, vector_in);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (IPV !== 4'd0 || ones !== 5'd1 || grp_last !== 1'b1 || out_fire !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_hold: got ipv=%h ones=%0d gl=%b fire=%b, required 0 1 1 0", IPV, ones, grp_last, out_fire);
        end
        wait_idle();
    endtask

    task automatic test_ipv();
        applyStimulus(8'd11, 8'd1, 1'b1, 1'b0);
        applyStimulus(8'd12, 8'd2, 1'b0, 1'b0);
        applyStimulus(8'd13, 8'd3, 1'b1, 1'b0);
        applyStimulus(8'd14, 8'd4, 1'b1, 1'b0);
        wait_idle();
        vectors++;
        if (IPV !== 4'd5 || ones !== 5'd3 || grp_last !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ipv_code: got ipv=%h ones=%0d gl=%b, required 5 3 1", IPV, ones, grp_last);
        end
    endtask

    task automatic test_back_to_back();
        int fc0 = fire_count;
        int guard = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(16 * (i + 1)), 8'(i + 1), (i % 3) == 0, 1'b0);
        end
        while (fire_count < fc0 + 2 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (fire_count < fc0 + 2 || (last_fire - prev_fire) != 6) begin
            miscompares++;
            $display("[TB] FAIL pacing: got fires=%0d spacing=%0d, required 2 fires 6 apart", fire_count - fc0, last_fire - prev_fire);
        end
        wait_idle();
    endtask

    task automatic test_partial_flush();
        applyStimulus(8'hFF, 8'd3, 1'b1, 1'b0);
        applyStimulus(8'd2, 8'd2, 1'b0, 1'b0);
        pulse_flush();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_fire !== 1'b1 || matrix_in !== 32'hFF020000 || vector_in !== 32'h03020000) begin
            miscompares++;
            $display("[TB] FAIL partial_data: got fire=%b m=%h v=%h, required 1 FF020000 03020000", out_fire, matrix_in, vector_in);
        end
        vectors++;
        if (IPV !== 4'd4 || ones !== 5'd2 || grp_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL partial_ipv: got ipv=%h ones=%0d gl=%b, required 4 2 0", IPV, ones, grp_last);
        end
        wait_idle();
        applyStimulus(8'd5, 8'd6, 1'b1, 1'b1);
        wait_idle();
    endtask

    task automatic test_flush_empty();
        int fc0 = fire_count;
        pulse_flush();
        repeat (8) @(negedge clk);
        vectors++;
        if (fire_count !== fc0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_empty: got %0d fires busy=%b, required 0 fires busy=0", fire_count - fc0, busy);
        end
    endtask

    task automatic test_zero_drop();
        applyStimulus(8'd9, 8'd1, 1'b0, 1'b0);
        applyStimulus(8'd0, 8'd5, 1'b1, 1'b0);
        applyStimulus(8'd10, 8'd2, 1'b0, 1'b0);
        applyStimulus(8'd11, 8'd3, 1'b1, 1'b0);
        applyStimulus(8'd12, 8'd4, 1'b0, 1'b0);
        wait_idle();
        vectors++;
        if (err_zero !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_zero_set: got %b, required 1", err_zero);
        end
    endtask

    task automatic test_mid_reset();
        int fc0;
        applyStimulus(8'd21, 8'd1, 1'b0, 1'b0);
        applyStimulus(8'd22, 8'd2, 1'b1, 1'b0);
        applyStimulus(8'd23, 8'd3, 1'b0, 1'b0);
        lanes.delete();
        fc0 = fire_count;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || err_zero !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got in_ready=%b busy=%b err_zero=%b, required 1 0 0", in_ready, busy, err_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_flush();
        repeat (8) @(negedge clk);
        vectors++;
        if (fire_count !== fc0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_issue: got %0d fires, required 0", fire_count - fc0);
        end
        applyStimulus(8'd31, 8'd7, 1'b0, 1'b0);
        applyStimulus(8'd32, 8'd8, 1'b1, 1'b0);
        applyStimulus(8'd33, 8'd9, 1'b0, 1'b0);
        applyStimulus(8'd34, 8'd10, 1'b1, 1'b0);
        wait_idle();
    endtask

    initial begin
        $display("[TB] starting spmv_group_packer bench");
        test_reset();
        test_full_group();
        test_ipv();
        test_back_to_back();
        test_partial_flush();
        test_flush_empty();
        test_zero_drop();
        test_mid_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d groups outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
